pwl_sin_nco: RTL

- Clocked, multi-channel, numerically controlled sine-family generator.
- Each channel keeps a phase accumulator and interpolates a 2^SEGW-segment breakpoint table, producing one sample per clock: value plus segment slope.
- Generalises the fixed single-tone PWL sine source with run-time frequency, per-channel phase offset, amplitude, offset, waveform mode and restart.
- Feeds digital-domain stimulus and DAC models.

---
 rtl/pwl_sin_nco.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pwl_sin_nco.sv
// rtl/pwl_sin_nco.sv - multi-channel piecewise-linear sine/cosine/triangle/square NCO
// Four register ranks: issue (phase), lookup/interpolate, gain products, offset/saturate.
module pwl_sin_nco #(
    parameter int NCH  = 4,
    parameter int PHW  = 24,
    parameter int SEGW = 6,
    parameter int DW   = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               load,
    input  logic [PHW-1:0]     fcw,
    input  logic [NCH*PHW-1:0] ph_ofs,
    input  logic [DW-1:0]      amp,
    input  logic [DW-1:0]      offset,
    input  logic [1:0]         mode,
    output logic               out_valid,
    output logic [NCH*DW-1:0]  y,
    output logic [NCH*DW-1:0]  slope
);
    localparam int NSEG = 1 << SEGW;
    localparam int QS   = NSEG / 4;
    localparam int FW   = PHW - SEGW;
    localparam int IW   = DW + 1;
    localparam int MW   = IW + FW + 1;
    localparam int PW   = 2 * DW + 2;
    localparam longint PEAK_I = (64'sd1 <<< (DW - 1)) - 64'sd1;
    localparam logic signed [IW-1:0] PEAK = IW'(PEAK_I);
    localparam logic signed [PW-1:0] SMAX = PW'(PEAK_I);
    localparam logic [PHW-1:0] QTR = {2'b01, {(PHW-2){1'b0}}};

    // round(peak * sin(pi/2 * j/QS)) by a Q30 Taylor series, integer-only so it folds at elaboration
    function automatic longint quarter_sin(input int j);
        longint x, x2, term, sum;
        x    = (64'sd3373259426 * j) / (2 * QS);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> 30) / (2 * n * (2 * n + 1));
            sum  = sum + term;
        end
        return (PEAK_I * sum + (64'sd1 <<< 29)) >>> 30;
    endfunction

    function automatic logic signed [DW-1:0] tab_val(input int k, input bit tri_wave);
        int q, j;
        longint v;
        q = k / QS;
        j = (q % 2 == 0) ? k % QS : QS - k % QS;
        v = tri_wave ? (2 * PEAK_I * j + QS) / (2 * QS) : quarter_sin(j);
        return DW'((q >= 2) ? -v : v);
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SMAX) return DW'(SMAX);
        if (v < ~SMAX) return DW'(~SMAX);
        return v[DW-1:0];
    endfunction

    logic signed [DW-1:0] sin_tab [NSEG];
    logic signed [DW-1:0] tri_tab [NSEG];
    for (genvar i = 0; i < NSEG; i++) begin : g_tab
        localparam logic signed [DW-1:0] SIN_V = tab_val(i, 1'b0);
        localparam logic signed [DW-1:0] TRI_V = tab_val(i, 1'b1);
        assign sin_tab[i] = SIN_V;
        assign tri_tab[i] = TRI_V;
    end

    logic [PHW-1:0] acc;
    logic [PHW-1:0] ph1 [NCH];
    logic [1:0]     md1;
    logic [DW-1:0]  am1, am2, of1, of2, of3;
    logic           v1, v2, v3;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc <= '0;
            v1  <= 1'b0;
            md1 <= '0;
            am1 <= '0;
            of1 <= '0;
            for (int c = 0; c < NCH; c++) ph1[c] <= '0;
        end else begin
            v1 <= en && !load;
            if (load) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc + fcw;
                md1 <= mode;
                am1 <= amp;
                of1 <= offset;
                for (int c = 0; c < NCH; c++)
                    ph1[c] <= acc + ph_ofs[c*PHW +: PHW] + ((mode == 2'b01) ? QTR : '0);
            end
        end
    end

    logic [SEGW-1:0]      k;
    logic signed [IW-1:0] bk, bn;
    logic signed [MW-1:0] dw, fw_s, prod;
    logic signed [IW-1:0] ip_n [NCH];
    logic signed [IW-1:0] dl_n [NCH];

    always_comb begin
        k = '0; bk = '0; bn = '0; dw = '0; fw_s = '0; prod = '0;
        for (int c = 0; c < NCH; c++) begin
            k    = ph1[c][PHW-1 -: SEGW];
            bk   = IW'(md1[1] ? tri_tab[k] : sin_tab[k]);
            bn   = IW'(md1[1] ? tri_tab[k + SEGW'(1)] : sin_tab[k + SEGW'(1)]);
            dw   = MW'(bn - bk);
            fw_s = MW'({1'b0, ph1[c][FW-1:0]});
            prod = dw * fw_s;
            ip_n[c] = bk + IW'(prod >>> FW);
            dl_n[c] = bn - bk;
            if (md1 == 2'b11) begin
                ip_n[c] = ph1[c][PHW-1] ? -PEAK : PEAK;
                dl_n[c] = '0;
            end
        end
    end

    logic signed [IW-1:0] it2 [NCH];
    logic signed [IW-1:0] dl2 [NCH];
    logic signed [PW-1:0] ia, id, aa;
    logic signed [PW-1:0] py_n [NCH];
    logic signed [PW-1:0] ps_n [NCH];
    logic signed [PW-1:0] py3 [NCH];
    logic signed [PW-1:0] ps3 [NCH];

    always_comb begin
        ia = '0; id = '0;
        aa = PW'({1'b0, am2});
        for (int c = 0; c < NCH; c++) begin
            ia = PW'(it2[c]);
            id = PW'(dl2[c]);
            py_n[c] = (ia * aa) >>> (DW - 1);
            ps_n[c] = (id * aa) >>> (DW - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v2 <= 1'b0; v3 <= 1'b0; out_valid <= 1'b0;
            am2 <= '0; of2 <= '0; of3 <= '0;
            y <= '0; slope <= '0;
            for (int c = 0; c < NCH; c++) begin
                it2[c] <= '0; dl2[c] <= '0; py3[c] <= '0; ps3[c] <= '0;
            end
        end else begin
            v2 <= v1;
            v3 <= v2;
            out_valid <= v3;
            am2 <= am1;
            of2 <= of1;
            of3 <= of2;
            for (int c = 0; c < NCH; c++) begin
                it2[c] <= ip_n[c];
                dl2[c] <= dl_n[c];
                py3[c] <= py_n[c];
                ps3[c] <= ps_n[c];
            end
            // idle cycles leave the last sample on the outputs
            if (v3) begin
                for (int c = 0; c < NCH; c++) begin
                    y[c*DW +: DW]     <= sat(PW'($signed(of3)) + py3[c]);
                    slope[c*DW +: DW] <= sat(ps3[c]);
                end
            end
        end
    end
endmodule
